// File: rtl/csa16_sub_pipe.sv
// Two-stage pipelined 16-bit subtractor (a - b - Bin) with carry-select upper byte,
// valid/ready handshake on both sides and borrow, overflow and zero flags.
module csa16_sub_pipe #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         Bout,
  output logic         ovf,
  output logic         zero
);

  if (W != 16) begin : g_w_check
    $error("csa16_sub_pipe supports only W = 16");
  end

  function automatic logic [8:0] byte_add(input logic [7:0] x, input logic [7:0] z,
                                          input logic cin);
    return {1'b0, x} + {1'b0, z} + {8'b0, cin};
  endfunction

  logic       vld_p1, vld_p2;
  logic       adv_p2, load_p1;
  logic [8:0] lo_sum, hi0_sum, hi1_sum;

  logic [7:0] lo_p1;
  logic       lc_p1;
  logic [8:0] hi0_p1, hi1_p1;
  logic       a15_p1, b15_p1;

  logic [8:0]  hi_sel;
  logic [15:0] y_next;
  logic [15:0] y_p2;
  logic        bout_p2, ovf_p2, zero_p2;

  // Stage 2 is free when empty or draining; stage 1 refills whenever stage 1 moves on.
  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv_p2;
  assign load_p1  = in_valid && in_ready;

  // Subtraction as a + ~b + ~Bin; both upper-byte candidates are formed up front.
  assign lo_sum  = byte_add(a[7:0], ~b[7:0], ~Bin);
  assign hi0_sum = byte_add(a[15:8], ~b[15:8], 1'b0);
  assign hi1_sum = byte_add(a[15:8], ~b[15:8], 1'b1);

  // ---- stage 1 boundary ----
  always_ff @(posedge clk) begin
    if (load_p1) begin
      lo_p1  <= lo_sum[7:0];
      lc_p1  <= lo_sum[8];
      hi0_p1 <= hi0_sum;
      hi1_p1 <= hi1_sum;
      a15_p1 <= a[15];
      b15_p1 <= b[15];
    end
  end

  // Carry out of the add is the complement of borrow out of the subtraction.
  assign hi_sel = lc_p1 ? hi1_p1 : hi0_p1;
  assign y_next = {hi_sel[7:0], lo_p1};

  // ---- stage 2 boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      y_p2    <= '0;
      bout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
    end else begin
      if (in_ready)
        vld_p1 <= in_valid;
      if (adv_p2)
        vld_p2 <= vld_p1;
      if (adv_p2 && vld_p1) begin
        y_p2    <= y_next;
        bout_p2 <= ~hi_sel[8];
        ovf_p2  <= (a15_p1 != b15_p1) && (y_next[15] != a15_p1);
        zero_p2 <= (y_next == 16'h0000);
      end
    end
  end

  assign out_valid = vld_p2;
  assign y         = y_p2;
  assign Bout      = bout_p2;
  assign ovf       = ovf_p2;
  assign zero      = zero_p2;

endmodule

// File: tb/tb_csa16_sub_pipe.sv
// Bench for csa16_sub_pipe: directed vectors, stall/back-to-back stream,
// randomized handshake traffic against an arithmetic model, and mid-flight reset.
module tb_csa16_sub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, y;
  logic        Bin, Bout, ovf, zero;

  int tests = 0;
  int fails = 0;

  csa16_sub_pipe #(.W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .Bout(Bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction, unsigned for y/Bout, signed range for ovf.
  function automatic logic [18:0] ref_sub(input logic [15:0] x, input logic [15:0] z,
                                          input logic bin);
    int d, sd;
    logic [15:0] r;
    logic bo, ov;
    d  = int'(x) - int'(z) - int'(bin);
    sd = int'($signed(x)) - int'($signed(z)) - int'(bin);
    r  = d[15:0];
    bo = (d < 0);
    ov = (sd > 32767) || (sd < -32768);
    return {r, bo, ov, (r == 16'h0000)};
  endfunction

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] y;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[5] = '{
    '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0},
    '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0},
    '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1},
    '{16'h00FF, 16'hFFFF, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0}
  };

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if ({y, Bout, ovf, zero} !== 19'h0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", {y, Bout, ovf, zero}); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    foreach (vecs[i]) begin
      out_ready = 1'b1; in_valid = 1'b1;
      a = vecs[i].a; b = vecs[i].b; Bin = vecs[i].bin;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); Bin = 1'($urandom);
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if ({out_valid, y, Bout, ovf, zero} !== {1'b1, vecs[i].y, vecs[i].bout, vecs[i].ovf, vecs[i].zero}) begin
        fails++;
        $display("FAIL dir%0d_result got v=%b y=%h B=%b o=%b z=%b exp v=1 y=%h B=%b o=%b z=%b", i,
                 out_valid, y, Bout, ovf, zero, vecs[i].y, vecs[i].bout, vecs[i].ovf, vecs[i].zero);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp_q[$];
    logic [18:0] got, held, exp;
    bit stall_prev, saw_full;
    int sent, rcvd;
    stall_prev = 0; saw_full = 0; sent = 0; rcvd = 0; held = '0;
    for (int c = 0; c < 40 && !(sent == 8 && rcvd == 8); c++) begin
      in_valid  = (sent < 8);
      out_ready = !(c >= 3 && c <= 6);
      a = 16'($urandom); b = 16'($urandom); Bin = 1'($urandom);
      @(negedge clk);
      got = {y, Bout, ovf, zero};
      if (c <= 2) begin
        tests++; if (out_valid !== (c == 2)) begin fails++; $display("FAIL b2b_latency c=%0d got=%b exp=%b", c, out_valid, (c == 2)); end
      end
      tests++;
      if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
        fails++; $display("FAIL b2b_in_ready c=%0d got=%b exp=%b", c, in_ready, ((exp_q.size() < 2) || out_ready));
      end
      if (in_ready === 1'b0) saw_full = 1;
      if (stall_prev) begin
        tests++; if ({out_valid, got} !== {1'b1, held}) begin fails++; $display("FAIL b2b_stall_hold c=%0d got=%h exp=%h", c, {out_valid, got}, {1'b1, held}); end
      end
      if (out_valid && out_ready) begin
        tests++; rcvd++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_extra_result got=%h exp=none", got); end
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin fails++; $display("FAIL b2b_result c=%0d got=%h exp=%h", c, got, exp); end
        end
      end
      stall_prev = out_valid && !out_ready; held = got;
      if (in_valid && in_ready) begin exp_q.push_back(ref_sub(a, b, Bin)); sent++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++; if (rcvd !== 8 || sent !== 8) begin fails++; $display("FAIL b2b_count got sent=%0d rcvd=%0d exp 8/8", sent, rcvd); end
    tests++; if (!saw_full) begin fails++; $display("FAIL b2b_backpressure got in_ready never 0 exp 0 seen"); end
  endtask

  task automatic test_random();
    logic [18:0] exp_q[$];
    logic [18:0] got, held, exp;
    bit stall_prev;
    stall_prev = 0; held = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      a = 16'($urandom); b = 16'($urandom); Bin = 1'($urandom);
      case ($urandom_range(0, 5))
        0: b = a;
        1: begin a = 16'h8000; b = 16'($urandom_range(0, 2)); end
        2: begin a[7:0] = b[7:0]; end
        default: ;
      endcase
      @(negedge clk);
      got = {y, Bout, ovf, zero};
      tests++;
      if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
        fails++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, ((exp_q.size() < 2) || out_ready));
      end
      if (stall_prev) begin
        tests++; if ({out_valid, got} !== {1'b1, held}) begin fails++; $display("FAIL rnd_stall_hold c=%0d got=%h exp=%h", c, {out_valid, got}, {1'b1, held}); end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL rnd_extra_result got=%h exp=none", got); end
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin fails++; $display("FAIL rnd_result c=%0d got=%h exp=%h", c, got, exp); end
        end
      end
      stall_prev = out_valid && !out_ready; held = got;
      if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b, Bin));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got = {y, Bout, ovf, zero};
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL rnd_drain_extra got=%h exp=none", got); end
        else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin fails++; $display("FAIL rnd_drain_result got=%h exp=%h", got, exp); end
        end
      end
      @(posedge clk); #1;
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rnd_lost_results got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [18:0] exp;
    int seen;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      a = 16'($urandom); b = 16'($urandom); Bin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b10) begin fails++; $display("FAIL mid_full got v/r=%b%b exp=10", out_valid, in_ready); end
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    tests++; if ({y, Bout, ovf, zero} !== 19'h0) begin fails++; $display("FAIL mid_rst_outputs got=%h exp=0", {y, Bout, ovf, zero}); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    a = 16'h4321; b = 16'h1234; Bin = 1'b1;
    exp = ref_sub(a, b, Bin);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (out_valid !== (k == 2)) begin fails++; $display("FAIL post_rst_valid k=%0d got=%b exp=%b", k, out_valid, (k == 2)); end
      if (out_valid) begin
        seen++;
        tests++; if ({y, Bout, ovf, zero} !== exp) begin fails++; $display("FAIL post_rst_result got=%h exp=%h", {y, Bout, ovf, zero}, exp); end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL post_rst_count got=%0d exp=1", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csa16_sub_pipe.md
CSA16_SUB_PIPE -- requirements
Module: csa16_sub_pipe

Interface
REQ-001 SHALL have parameter W, default 16: operand width; only 16 is supported, any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: a, b and Bin are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1: block accepts an operand set this cycle.
REQ-006 SHALL have port a, input, 16: minuend.
REQ-007 SHALL have port b, input, 16: subtrahend.
REQ-008 SHALL have port Bin, input, 1: borrow-in.
REQ-009 SHALL have port out_valid, output, 1: y and flags hold a result.
REQ-010 SHALL have port out_ready, input, 1: downstream takes the result this cycle.
REQ-011 SHALL have port y, output, 16: difference.
REQ-012 SHALL have port Bout, output, 1: borrow-out.
REQ-013 SHALL have port ovf, output, 1: signed overflow.
REQ-014 SHALL have port zero, output, 1: y equals 0.

Function
REQ-015 SHALL accept an operand set on a rising edge where in_valid=1 and in_ready=1.
REQ-016 SHALL compute y = (a - b - Bin) mod 2^16, implemented as a + ~b + ~Bin.
REQ-017 SHALL set Bout=1 iff unsigned a < b + Bin.
REQ-018 SHALL set ovf=1 iff a[15] != b[15] and y[15] != a[15].
REQ-019 SHALL set zero=1 iff y == 16'h0000.
REQ-020 SHALL have stage 1 register the low byte of the difference, its carry, and both candidate upper bytes with carries (for carry-in 0 and 1), plus a[15] and b[15].
REQ-021 SHALL have stage 2 select the upper byte and carry from the registered low-byte carry, then register y, Bout, ovf, zero and out_valid.
REQ-022 SHALL give out_valid=1 with the result immediately after the 2nd rising edge following acceptance, when there is no stall: latency 2, throughput 1 per cycle.
REQ-023 SHALL be a stall: out_valid=1 and out_ready=0; during a stall y, Bout, ovf, zero and out_valid SHALL hold stable.
REQ-024 SHALL allow stage 1 to advance only when stage 2 is empty or draining (out_ready=1).
REQ-025 SHALL drive in_ready = !s1_valid || stage-1 advancing, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-026 SHALL, under a continuous stall, hold at most 2 results in flight; in_ready SHALL go 0 once both stages are full.
REQ-027 SHALL, on simultaneous accept and drain when both stages are full, shift all stages in the same edge with no loss or duplication.
REQ-028 SHALL hold operand values on input ports while in_valid=0 without affecting state.
REQ-029 SHALL leave y and flags don't-care while out_valid=0; they are otherwise held at last value.

Reset
REQ-030 SHALL, on rst=1 and independent of clk, force out_valid=0, internal valids=0, and y, Bout, ovf, zero to 0.
REQ-031 SHALL hold in_ready=1 while rst=1 and immediately after release.
REQ-032 SHALL discard in-flight results on reset mid-operation; no out_valid pulse SHALL follow from pre-reset operands.
REQ-033 SHALL allow the first acceptance on the first rising edge after rst deasserts.

Verification
REQ-034 SHALL cover: a=16'h0005, b=16'h0003, Bin=0, out_ready=1 -> 2 cycles later y=16'h0002, Bout=0, ovf=0, zero=0.
REQ-035 SHALL cover: a=16'h0000, b=16'h0001, Bin=0 -> y=16'hFFFF, Bout=1, ovf=0, zero=0.
REQ-036 SHALL cover: a=16'h8000, b=16'h0001, Bin=0 -> y=16'h7FFF, Bout=0, ovf=1; and a=16'h1234, b=16'h1233, Bin=1 -> y=0, zero=1, Bout=0.
REQ-037 SHALL cover: a=16'h00FF, b=16'hFFFF, Bin=1 (low-byte borrow select path) -> y=16'h00FF, Bout=1.
REQ-038 SHALL cover: back-to-back stream of 8 operand sets with out_ready=0 for cycles 3-6 -> in_ready=0 once 2 results are held, outputs stable during stall, all 8 results delivered in order, none lost or duplicated.
REQ-039 SHALL cover: rst pulsed while 2 results are in flight -> out_valid=0 at once, in_ready=1, and no stale result appears afterwards.
